// File: rtl/ula_wb_buffer_pkg.sv
// Shared ula parameters: widths, opcode encodings, rflags bit positions and
// the writeback entry layout used between the execute and writeback stages.
package ula_wb_buffer_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int OPCODE_WIDTH   = 4;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int RFLAGS_WIDTH   = 5;

    localparam logic [OPCODE_WIDTH-1:0] ADD = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] SUB = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] MUL = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] DIV = 4'd3;
    localparam logic [OPCODE_WIDTH-1:0] AND = 4'd4;
    localparam logic [OPCODE_WIDTH-1:0] OR  = 4'd5;
    localparam logic [OPCODE_WIDTH-1:0] NOT = 4'd6;
    localparam logic [OPCODE_WIDTH-1:0] CMP = 4'd7;

    localparam int RFLAG_OVERFLOW = 4;
    localparam int RFLAG_ABOVE    = 3;
    localparam int RFLAG_EQUAL    = 2;
    localparam int RFLAG_BELOW    = 1;
    localparam int RFLAG_ERROR    = 0;

    // A result is only written back if the instruction asked for it, it is
    // not a compare, and the ula did not flag it as erroneous.
    function automatic logic write_allowed(
        input logic                    we,
        input logic [OPCODE_WIDTH-1:0] opcode,
        input logic [RFLAGS_WIDTH-1:0] rflags
    );
        return we && (opcode != CMP) && !rflags[RFLAG_ERROR];
    endfunction

endpackage

// File: rtl/ula_wb_fifo2.sv
// Generic 2-entry valid/ready FIFO. Two storage slots addressed by 1-bit
// read/write pointers that wrap; ready/valid come from the registered count.
module ula_wb_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign push_ready = (count != 2'd2);
    assign pop_valid  = (count != 2'd0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = mem[rd_ptr];

    // Storage, pointers and occupancy; a simultaneous push and pop leaves
    // the count unchanged while both pointers advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ula_wb_buffer.sv
// Writeback stage behind the ula: buffers results in a 2-entry skid FIFO,
// presents gated register writes, and tracks flags, sticky error and commits.
module ula_wb_buffer #(
    parameter int DATA_WIDTH     = ula_wb_buffer_pkg::DATA_WIDTH,
    parameter int OPCODE_WIDTH   = ula_wb_buffer_pkg::OPCODE_WIDTH,
    parameter int REG_ADDR_WIDTH = ula_wb_buffer_pkg::REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_WIDTH-1:0]   in_opcode,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [4:0]                in_rflags,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_we,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic                      wb_we,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [4:0]                flags_q,
    output logic                      err_sticky,
    input  logic                      err_clr,
    output logic [CNT_WIDTH-1:0]      commit_count
);

    import ula_wb_buffer_pkg::*;

    localparam int PAYLOAD_WIDTH = OPCODE_WIDTH + DATA_WIDTH + 5 + REG_ADDR_WIDTH + 1;

    logic                      rst_done;
    logic                      fifo_push_ready;
    logic                      fifo_pop_valid;
    logic [PAYLOAD_WIDTH-1:0]  tail_payload;
    logic [PAYLOAD_WIDTH-1:0]  head_payload;
    logic [OPCODE_WIDTH-1:0]   head_opcode;
    logic [DATA_WIDTH-1:0]     head_data;
    logic [4:0]                head_rflags;
    logic [REG_ADDR_WIDTH-1:0] head_rd;
    logic                      head_we;
    logic                      pop;

    assign tail_payload = {in_opcode, in_data, in_rflags, in_rd, in_we};
    assign {head_opcode, head_data, head_rflags, head_rd, head_we} = head_payload;

    // The buffer refuses input for the first cycle after reset so every
    // output, including in_ready, reads zero until one clean edge has passed.
    assign in_ready = rst_done && fifo_push_ready;
    assign wb_valid = fifo_pop_valid;
    assign pop      = wb_valid && wb_ready;
    assign wb_we    = wb_valid &&
                      write_allowed(head_we, OPCODE_WIDTH'(head_opcode), head_rflags);
    assign wb_addr  = wb_valid ? head_rd   : '0;
    assign wb_data  = wb_valid ? head_data : '0;

    ula_wb_fifo2 #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid && rst_done),
        .push_ready (fifo_push_ready),
        .push_data  (tail_payload),
        .pop_valid  (fifo_pop_valid),
        .pop_ready  (wb_ready),
        .pop_data   (head_payload)
    );

    // Marks that at least one edge has elapsed since reset was released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Commit bookkeeping: every popped entry updates flags and the counter,
    // even when its register write was suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q      <= '0;
            commit_count <= '0;
        end else if (pop) begin
            flags_q      <= head_rflags;
            commit_count <= commit_count + CNT_WIDTH'(1);
        end
    end

    // Sticky error: a committed ERROR sets it and wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (pop && head_rflags[RFLAG_ERROR]) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: doc/ula_wb_buffer.md
Name: ula_wb_buffer

Overview:
Writeback stage directly downstream of the ula. It captures each ula result with its flags and destination register into a 2-entry skid buffer, and presents committed writes to the register file over a valid/ready handshake. It also holds the architectural flags register, a sticky error flag and a commit counter. Back-pressure from the register file propagates to the execute stage through in_ready.

Parameters:
DATA_WIDTH, 16, ula operand/result width (shared params)
OPCODE_WIDTH, 4, ula opcode width (shared params)
REG_ADDR_WIDTH, 4, register-file address width
CNT_WIDTH, 16, commit counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  execute stage presents a result
in_ready  output  1  buffer can accept (count < 2)
in_opcode  input  OPCODE_WIDTH  opcode that produced the result
in_data  input  DATA_WIDTH  ula out
in_rflags  input  5  ula rflags {OVERFLOW, ABOVE, EQUAL, BELOW, ERROR}
in_rd  input  REG_ADDR_WIDTH  destination register
in_we  input  1  instruction requests register write
wb_valid  output  1  head entry present
wb_ready  input  1  register file accepts head
wb_we  output  1  write enable for head
wb_addr  output  REG_ADDR_WIDTH  head destination
wb_data  output  DATA_WIDTH  head result
flags_q  output  5  flags of last committed entry
err_sticky  output  1  set by any committed ERROR
err_clr  input  1  clears err_sticky
commit_count  output  CNT_WIDTH  number of committed entries

Behaviour:
- Reset (async, any time): count=0, both entries cleared, flags_q=0, err_sticky=0, commit_count=0. Any in-flight entries are discarded. All outputs are 0 during reset and in the first cycle after it.
- Push: in_valid && in_ready. The entry {opcode, data, rflags, rd, we} is written to the tail.
- Pop: wb_valid && wb_ready. The head is removed.
- in_ready = (count != 2). It is derived from registered count only, with no combinational path from wb_ready.
- wb_valid = (count != 0). When wb_valid=0, wb_we/wb_addr/wb_data are forced to 0.
- Latency: a push into an empty buffer at edge N makes wb_valid=1 after edge N. There is no same-cycle bypass.
- Ordering is strict FIFO. Entries are stored in a 2-slot array with 1-bit rd/wr pointers that wrap.
- Simultaneous push and pop: count unchanged. Allowed at count=1. At count=0 a pop is impossible. At count=2 a push is impossible.
- Holding rule: while wb_valid && !wb_ready, the wb_* outputs stay stable.
- wb_we = head.we && head.opcode != CMP && head.rflags[0] == 0. CMP never writes, and an errored result (e.g. DIV by 0) is never written.
- On pop, every opcode, including suppressed writes, causes:
  - flags_q <= head.rflags
  - commit_count <= commit_count + 1, wrapping at 2^CNT_WIDTH
  - err_sticky <= 1 if head.rflags[0]
- err_clr: clears err_sticky. If err_clr coincides with a pop whose ERROR=1, the set wins and err_sticky = 1.
- A pop with wb_we=0 still counts as a commit.

Decomposition:
- Opcode constants (ADD, SUB, MUL, DIV, AND, OR, NOT, CMP) and DATA_WIDTH/OPCODE_WIDTH come from the shared params include.
- Add to that include: RFLAG_* bit indices (OVERFLOW=4, ABOVE=3, EQUAL=2, BELOW=1, ERROR=0) and REG_ADDR_WIDTH.
- One sub-module: ula_wb_fifo2. It is the generic 2-entry valid/ready FIFO (payload width parameter, count, pointers). The top module adds write gating, flags, sticky error and counter.

Test Plan:
- Basic commit: wb_ready=1; push ADD, data=15, rflags=00000, rd=3, we=1 -> next cycle wb_valid=1, wb_we=1, wb_addr=3, wb_data=15; after pop flags_q=00000, commit_count=1.
- Back-pressure: wb_ready=0; attempt 3 pushes (5, -8, 32767) -> first two accepted and in_ready=0 after them; third held. Release wb_ready -> order 5, -8, 32767, count returns to 0, commit_count=3.
- Simultaneous push/pop at count=1: continuous stream of 10 results with wb_ready=1 -> one commit per cycle, in_ready stays 1, data order preserved.
- CMP: push CMP 5 vs 5, rflags=00100, we=1 -> wb_we=0; after pop flags_q=00100, commit_count increments.
- DIV by zero: push DIV 6/0, rflags=00001, we=1 -> wb_we=0, err_sticky=1 after pop. Assert err_clr in a later idle cycle -> err_sticky=0. Assert err_clr in the same cycle as another ERROR pop -> err_sticky=1.
- Reset mid-operation: fill 2 entries with wb_ready=0, pulse rst between edges -> immediately wb_valid=0, in_ready=0 while rst=1, flags_q=0, commit_count=0. After release, in_ready=1 and no stale entry appears.
